// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit:
// FSM states, opcodes, ALU operation classes/codes and datapath mux selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Base codes are the 3-bit set zero-extended; the extended set needs bit 3.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_base_funct3(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Maps ALU operation class plus funct fields to an ALUControl code; the
// extended operation set is only decoded when EXT_ALU is non-zero.
module riscv_alu_decoder
    import riscv_pkg::*;
#(
    parameter int EXT_ALU = 0,
    parameter int ACW     = (EXT_ALU != 0) ? 4 : 3
) (
    input  aluop_t           ALUOp,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             op5,
    output logic [ACW-1:0]   ALUControl
);

    logic [3:0] w_code;

    always_comb begin
        w_code = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: w_code = ALU_ADD;
            ALUOP_SUB: w_code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5 = 1) uses funct7b5 to select subtract.
                    3'b000:  w_code = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_code = ALU_SLT;
                    3'b110:  w_code = ALU_OR;
                    3'b111:  w_code = ALU_AND;
                    3'b100:  if (EXT_ALU != 0) w_code = ALU_XOR;
                    3'b001:  if (EXT_ALU != 0) w_code = ALU_SLL;
                    3'b101:  if (EXT_ALU != 0) w_code = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b011:  if (EXT_ALU != 0) w_code = ALU_SLTU;
                    default: w_code = ALU_ADD;
                endcase
            end
            default: w_code = ALU_ADD;
        endcase
    end

    assign ALUControl = w_code[ACW-1:0];

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a unified memory with a ready handshake, and traps on illegal encodings.
module riscv_multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int EXT_ALU = 0,
    parameter int ACW     = (EXT_ALU != 0) ? 4 : 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [ACW-1:0]   ALUControl,
    output logic             retire,
    output logic             illegal
);

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    aluop_t w_aluop;
    logic   w_funct_ok;
    logic   w_mem_req, w_memwrite, w_irwrite, w_pcwrite, w_regwrite, w_retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP) r_illegal <= 1'b1;
        end
    end

    assign w_funct_ok = (EXT_ALU != 0) || is_base_funct3(funct3);

    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_retire   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        w_aluop    = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = w_funct_ok ? S_EXECR : S_TRAP;
                    OP_ITYPE:     w_next = w_funct_ok ? S_EXECI : S_TRAP;
                    OP_BRANCH:    w_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                AdrSrc    = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                AdrSrc     = 1'b1;
                w_retire   = mem_ready;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                w_aluop = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                w_aluop = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                // funct3[0] distinguishes bne from beq, so it inverts the taken sense.
                ALUSrcA   = SRCA_RS1;
                w_aluop   = ALUOP_SUB;
                w_pcwrite = Zero ^ funct3[0];
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:     ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    riscv_alu_decoder #(
        .EXT_ALU (EXT_ALU),
        .ACW     (ACW)
    ) u_alu_dec (
        .ALUOp      (w_aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl)
    );

    // State-changing strobes are suppressed while reset is held.
    assign mem_req  = w_mem_req  & ~reset;
    assign MemWrite = w_memwrite & ~reset;
    assign IRWrite  = w_irwrite  & ~reset;
    assign PCWrite  = w_pcwrite  & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign retire   = w_retire   & ~reset;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: a cycle-by-cycle vector table for the
// base-ALU build plus short sequences exercising the extended-ALU build.
module tb_riscv_multicycle_ctrl;

    localparam logic [6:0] OR_ = 7'h33;
    localparam logic [6:0] OI_ = 7'h13;
    localparam logic [6:0] OLW = 7'h03;
    localparam logic [6:0] OSW = 7'h23;
    localparam logic [6:0] OBR = 7'h63;
    localparam logic [6:0] OJL = 7'h6F;

    // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, illegal}
    localparam logic [7:0] EN0  = 8'b00000000;
    localparam logic [7:0] EF1  = 8'b10011000;
    localparam logic [7:0] EF0  = 8'b10000000;
    localparam logic [7:0] EMR  = 8'b10100000;
    localparam logic [7:0] EWB  = 8'b00000110;
    localparam logic [7:0] EMW1 = 8'b11100010;
    localparam logic [7:0] EMW0 = 8'b11100000;
    localparam logic [7:0] EBT  = 8'b00001010;
    localparam logic [7:0] EBN  = 8'b00000010;
    localparam logic [7:0] EJL  = 8'b00001000;
    localparam logic [7:0] ETR  = 8'b00000001;
    localparam logic [7:0] EMWR = 8'b00100000;

    typedef struct packed {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        rdy;
        logic [18:0] ex;
    } vec_t;

    vec_t  tbl[$];
    string nm[$];
    int    n_chk = 0;
    int    n_fail = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, rdy;

    logic       mreq0, mw0, adr0, irw0, pcw0, rw0, ret0, ill0;
    logic [1:0] sa0, sb0, rs0, im0;
    logic [2:0] ac0;
    logic       mreq1, mw1, adr1, irw1, pcw1, rw1, ret1, ill1;
    logic [1:0] sa1, sb1, rs1, im1;
    logic [3:0] ac1;
    logic [18:0] got0;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(.EXT_ALU(0)) dut0 (
        .clk(clk), .reset(rst), .op(op), .funct3(f3), .funct7b5(f7), .Zero(z),
        .mem_ready(rdy), .mem_req(mreq0), .MemWrite(mw0), .AdrSrc(adr0),
        .IRWrite(irw0), .PCWrite(pcw0), .RegWrite(rw0), .ALUSrcA(sa0),
        .ALUSrcB(sb0), .ResultSrc(rs0), .ImmSrc(im0), .ALUControl(ac0),
        .retire(ret0), .illegal(ill0)
    );

    riscv_multicycle_ctrl #(.EXT_ALU(1)) dut1 (
        .clk(clk), .reset(rst), .op(op), .funct3(f3), .funct7b5(f7), .Zero(z),
        .mem_ready(rdy), .mem_req(mreq1), .MemWrite(mw1), .AdrSrc(adr1),
        .IRWrite(irw1), .PCWrite(pcw1), .RegWrite(rw1), .ALUSrcA(sa1),
        .ALUSrcB(sb1), .ResultSrc(rs1), .ImmSrc(im1), .ALUControl(ac1),
        .retire(ret1), .illegal(ill1)
    );

    assign got0 = {mreq0, mw0, adr0, irw0, pcw0, rw0, ret0, ill0, sa0, sb0, rs0, im0, ac0};

    function automatic logic [18:0] e(input logic [7:0] en, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] r,
                                      input logic [1:0] i, input logic [2:0] c);
        return {en, a, b, r, i, c};
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f,
                       input logic s, input logic zz, input logic rd,
                       input logic [18:0] x, input string n);
        vec_t v;
        v.rst = r; v.op = o; v.f3 = f; v.f7 = s; v.z = zz; v.rdy = rd; v.ex = x;
        tbl.push_back(v);
        nm.push_back(n);
    endtask

    task automatic cyc(input logic r, input logic [6:0] o, input logic [2:0] f,
                       input logic s, input logic zz, input logic rd);
        @(negedge clk);
        rst = r; op = o; f3 = f; f7 = s; z = zz; rdy = rd;
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // Reset, then FETCH/DECODE/EXEC/WB on the extended build; base build state only checked for trap.
    task automatic run_ext(input logic [6:0] o, input logic [2:0] f, input logic s,
                           input logic [3:0] ctl, input logic trap0, input string n);
        cyc(1, o, f, s, 0, 1);
        cyc(0, o, f, s, 0, 1);
        cyc(0, o, f, s, 0, 1);
        cyc(0, o, f, s, 0, 1);
        chk({n, "_ctl1"}, {28'd0, ac1}, {28'd0, ctl});
        chk({n, "_ill0"}, {31'd0, ill0}, {31'd0, trap0});
        cyc(0, o, f, s, 0, 1);
        chk({n, "_wb1"}, {30'd0, rw1, ret1}, 32'd3);
    endtask

    initial begin
        rst = 1'b1; op = OR_; f3 = 3'b000; f7 = 1'b0; z = 1'b0; rdy = 1'b1;

        add(1, OR_, 3'b000, 0, 0, 1, e(EN0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "rst_c0");
        add(1, OR_, 3'b000, 0, 0, 1, e(EN0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "rst_c1");
        add(0, OR_, 3'b000, 0, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "add_F");
        add(0, OR_, 3'b000, 0, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000), "add_D");
        add(0, OR_, 3'b000, 0, 0, 1, e(EN0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000), "add_X");
        add(0, OR_, 3'b000, 0, 0, 1, e(EWB, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "add_WB");
        add(0, OR_, 3'b000, 1, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "sub_F");
        add(0, OR_, 3'b000, 1, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000), "sub_D");
        add(0, OR_, 3'b000, 1, 0, 1, e(EN0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001), "sub_X");
        add(0, OR_, 3'b000, 1, 0, 1, e(EWB, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "sub_WB");
        add(0, OI_, 3'b000, 1, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "addi_F");
        add(0, OI_, 3'b000, 1, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000), "addi_D");
        add(0, OI_, 3'b000, 1, 0, 1, e(EN0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000), "addi_X");
        add(0, OI_, 3'b000, 1, 0, 1, e(EWB, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "addi_WB");
        add(0, OR_, 3'b010, 0, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "slt_F");
        add(0, OR_, 3'b010, 0, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000), "slt_D");
        add(0, OR_, 3'b010, 0, 0, 1, e(EN0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b101), "slt_X");
        add(0, OR_, 3'b010, 0, 0, 1, e(EWB, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "slt_WB");
        add(0, OI_, 3'b110, 0, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "ori_F");
        add(0, OI_, 3'b110, 0, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000), "ori_D");
        add(0, OI_, 3'b110, 0, 0, 1, e(EN0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b011), "ori_X");
        add(0, OI_, 3'b110, 0, 0, 1, e(EWB, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "ori_WB");
        add(0, OLW, 3'b010, 0, 0, 0, e(EF0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "lw_Fw0");
        add(0, OLW, 3'b010, 0, 0, 0, e(EF0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "lw_Fw1");
        add(0, OLW, 3'b010, 0, 0, 0, e(EF0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "lw_Fw2");
        add(0, OLW, 3'b010, 0, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "lw_F");
        add(0, OLW, 3'b010, 0, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000), "lw_D");
        add(0, OLW, 3'b010, 0, 0, 1, e(EN0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000), "lw_MA");
        add(0, OLW, 3'b010, 0, 0, 0, e(EMR, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "lw_MRw0");
        add(0, OLW, 3'b010, 0, 0, 0, e(EMR, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "lw_MRw1");
        add(0, OLW, 3'b010, 0, 0, 1, e(EMR, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "lw_MR");
        add(0, OLW, 3'b010, 0, 0, 1, e(EWB, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000), "lw_WB");
        add(0, OSW, 3'b010, 0, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b01, 3'b000), "sw_F");
        add(0, OSW, 3'b010, 0, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b01, 3'b000), "sw_D");
        add(0, OSW, 3'b010, 0, 0, 1, e(EN0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000), "sw_MA");
        add(0, OSW, 3'b010, 0, 0, 1, e(EMW1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000), "sw_MW");
        add(0, OBR, 3'b000, 0, 1, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b10, 3'b000), "beq_F");
        add(0, OBR, 3'b000, 0, 1, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000), "beq_D");
        add(0, OBR, 3'b000, 0, 1, 1, e(EBT, 2'b10, 2'b00, 2'b00, 2'b10, 3'b001), "beq_z1");
        add(0, OBR, 3'b001, 0, 1, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b10, 3'b000), "bne1_F");
        add(0, OBR, 3'b001, 0, 1, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000), "bne1_D");
        add(0, OBR, 3'b001, 0, 1, 1, e(EBN, 2'b10, 2'b00, 2'b00, 2'b10, 3'b001), "bne_z1");
        add(0, OBR, 3'b001, 0, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b10, 3'b000), "bne0_F");
        add(0, OBR, 3'b001, 0, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000), "bne0_D");
        add(0, OBR, 3'b001, 0, 0, 1, e(EBT, 2'b10, 2'b00, 2'b00, 2'b10, 3'b001), "bne_z0");
        add(0, OJL, 3'b000, 0, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b11, 3'b000), "jal_F");
        add(0, OJL, 3'b000, 0, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b11, 3'b000), "jal_D");
        add(0, OJL, 3'b000, 0, 0, 1, e(EJL, 2'b01, 2'b10, 2'b00, 2'b11, 3'b000), "jal_J");
        add(0, OJL, 3'b000, 0, 0, 1, e(EWB, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000), "jal_WB");
        add(0, OSW, 3'b010, 0, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b01, 3'b000), "swr_F");
        add(0, OSW, 3'b010, 0, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b01, 3'b000), "swr_D");
        add(0, OSW, 3'b010, 0, 0, 1, e(EN0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000), "swr_MA");
        add(0, OSW, 3'b010, 0, 0, 0, e(EMW0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000), "swr_MWw");
        add(1, OSW, 3'b010, 0, 0, 0, e(EMWR, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000), "swr_rst");
        add(0, OR_, 3'b101, 1, 0, 0, e(EF0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "swr_back");
        add(0, OR_, 3'b101, 1, 0, 1, e(EF1, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "sra_F");
        add(0, OR_, 3'b101, 1, 0, 1, e(EN0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000), "sra_D");
        add(0, OR_, 3'b101, 1, 0, 1, e(ETR, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "sra_T0");
        add(0, OR_, 3'b101, 1, 0, 1, e(ETR, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "sra_T1");
        add(1, OR_, 3'b101, 1, 0, 0, e(ETR, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "trap_rst");
        add(0, OR_, 3'b101, 1, 0, 0, e(EF0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), "trap_clr");

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            rst = tbl[k].rst; op = tbl[k].op; f3 = tbl[k].f3;
            f7 = tbl[k].f7; z = tbl[k].z; rdy = tbl[k].rdy;
            #1;
            n_chk++;
            if (got0 !== tbl[k].ex) begin
                n_fail++;
                $display("FAIL %s [%0d]: got %b expected %b", nm[k], k, got0, tbl[k].ex);
            end
        end

        run_ext(OR_, 3'b101, 1'b1, 4'b1000, 1'b1, "ext_sra");
        run_ext(OI_, 3'b101, 1'b0, 4'b0111, 1'b1, "ext_srli");
        run_ext(OR_, 3'b100, 1'b0, 4'b0100, 1'b1, "ext_xor");
        run_ext(OI_, 3'b001, 1'b0, 4'b0110, 1'b1, "ext_slli");
        run_ext(OR_, 3'b011, 1'b0, 4'b1001, 1'b1, "ext_sltu");
        run_ext(OR_, 3'b000, 1'b1, 4'b0001, 1'b0, "ext_sub");
        run_ext(OR_, 3'b111, 1'b0, 4'b0010, 1'b0, "ext_and");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
